// File: rtl/pipeline_hazard_ctrl.sv
// Stall-side hazard control: load-use bubble, dcache freeze, stall watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall-cycle and load-use counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_STALL_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  Read_Register_1_ID_i,
    input  logic [4:0]  Read_Register_2_ID_i,
    input  logic [4:0]  Write_Register_EX_i,
    input  logic        MemRead_EX_i,
    input  logic        Mem_Stall_i,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        ID_EX_Bubble_o,
    output logic        Pipeline_Stall_o,
    output logic        Stall_Timeout_o,
    output logic [15:0] Mem_Miss_Count_o,
    output logic [31:0] Stall_Cycle_Count_o,
    output logic [15:0] Load_Use_Count_o
);

    localparam int WD_W = $clog2(MAX_STALL_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL_CYCLES);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     miss_q, miss_d;
    logic            lu;

    assign lu = MemRead_EX_i && (Write_Register_EX_i != 5'd0) &&
                ((Write_Register_EX_i == Read_Register_1_ID_i) ||
                 (Write_Register_EX_i == Read_Register_2_ID_i));

    // A dcache stall freezes EX as well, so a pending load-use waits it out.
    always_comb begin
        PC_Write_o       = 1'b1;
        IF_ID_Write_o    = 1'b1;
        ID_EX_Bubble_o   = 1'b0;
        Pipeline_Stall_o = 1'b0;
        if (rst_i) begin
            PC_Write_o    = 1'b1;
            IF_ID_Write_o = 1'b1;
        end else if (Mem_Stall_i) begin
            Pipeline_Stall_o = 1'b1;
            PC_Write_o       = 1'b0;
            IF_ID_Write_o    = 1'b0;
        end else if (lu) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN:      if (Mem_Stall_i) state_d = MEM_WAIT;
            MEM_WAIT: if (!Mem_Stall_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (state_q == RUN && Mem_Stall_i && miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end
        if (Mem_Stall_i) begin
            if (wd_q == WD_MAX) begin
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            miss_q    <= miss_d;
        end
    end

    assign Stall_Timeout_o  = timeout_q;
    assign Mem_Miss_Count_o = miss_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] lucnt_q, lucnt_d;

    always_comb begin
        cyc_d   = cyc_q;
        lucnt_d = lucnt_q;
        if (Mem_Stall_i) begin
            cyc_d = cyc_q + 32'd1;
        end
        if (ID_EX_Bubble_o && lucnt_q != 16'hFFFF) begin
            lucnt_d = lucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q   <= '0;
            lucnt_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            lucnt_q <= lucnt_d;
        end
    end

    assign Stall_Cycle_Count_o = cyc_q;
    assign Load_Use_Count_o    = lucnt_q;
`else
    assign Stall_Cycle_Count_o = 32'd0;
    assign Load_Use_Count_o    = 16'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall-side hazard controller for the 5-stage pipelined CPU. It handles the hazards that EX-stage forwarding cannot resolve. A load-use dependency inserts one bubble into ID/EX. A data-cache busy freezes the whole pipeline until the dcache releases it. The block also tracks dcache stall episodes, enforces a stall watchdog, and optionally keeps performance counters. It sits beside the forwarding logic and drives the write-enables of PC, IF/ID and the ID/EX bubble mux.

## Interface
Parameters:
- MAX_STALL_CYCLES, 1024: number of consecutive dcache-stall cycles that trips the watchdog (≥1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- Read_Register_1_ID_i  input  5  rs of the instruction in ID.
- Read_Register_2_ID_i  input  5  rt of the instruction in ID.
- Write_Register_EX_i  input  5  destination register of the instruction in EX.
- MemRead_EX_i  input  1  instruction in EX is a load.
- Mem_Stall_i  input  1  dcache busy (miss/refill/write-back); combinational from the dcache.
- PC_Write_o  output  1  1 = PC may update.
- IF_ID_Write_o  output  1  1 = IF/ID register may update.
- ID_EX_Bubble_o  output  1  1 = load zeroed control into ID/EX this cycle.
- Pipeline_Stall_o  output  1  1 = freeze all pipeline registers, including EX/MEM and MEM/WB.
- Stall_Timeout_o  output  1  sticky watchdog flag.
- Mem_Miss_Count_o  output  16  number of dcache stall episodes.
- Stall_Cycle_Count_o  output  32  number of cycles with Mem_Stall_i=1.
- Load_Use_Count_o  output  16  number of bubbles inserted.

## Operation
- FSM states:
  - RUN.
  - MEM_WAIT.
- FSM transitions:
  - RUN→MEM_WAIT on Mem_Stall_i=1.
  - MEM_WAIT→RUN on Mem_Stall_i=0.
  - Otherwise the state holds.
- Load-use hazard (lu) = MemRead_EX_i && Write_Register_EX_i≠0 && (Write_Register_EX_i==Read_Register_1_ID_i || Write_Register_EX_i==Read_Register_2_ID_i).
- Output priority, evaluated every cycle independent of state:
  - rst_i=1: PC_Write_o=1, IF_ID_Write_o=1, ID_EX_Bubble_o=0, Pipeline_Stall_o=0.
  - Else if Mem_Stall_i=1: Pipeline_Stall_o=1, PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=0. The hazard stays latent because EX is frozen too, and it is re-evaluated after release.
  - Else if lu: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, Pipeline_Stall_o=0.
  - Else: PC_Write_o=1, IF_ID_Write_o=1, others 0.
- One bubble always suffices for a load-use hazard: the next cycle EX holds the bubble (MemRead_EX_i=0) and forwarding covers MEM→EX.
- Watchdog counter (width ⌈log2(MAX_STALL_CYCLES+1)⌉):
  - Increments each cycle Mem_Stall_i=1 and saturates at MAX_STALL_CYCLES.
  - Clears on any cycle with Mem_Stall_i=0.
  - Stall_Timeout_o sets on the edge where the counter already equals MAX_STALL_CYCLES with Mem_Stall_i=1, and stays 1 until rst_i.
- Mem_Miss_Count_o increments on each RUN→MEM_WAIT transition and saturates at 0xFFFF. It is always present, regardless of configuration.

## Timing
- All four pipeline-control outputs are combinational from inputs (zero latency, same cycle).
- Registered outputs take effect the cycle after the causing edge.
- Reset values, applied on the clk_i edge with rst_i=1:
  - state=RUN.
  - watchdog=0.
  - Stall_Timeout_o=0.
  - All counters 0.
- Reset mid-stall: the state returns to RUN; if Mem_Stall_i is still 1 after reset, it counts as a new episode.
- Mem_Stall_i=1 and lu in the same cycle: the stall wins; no bubble and no Load_Use_Count_o increment.
- A stall of exactly MAX_STALL_CYCLES cycles does not trip the watchdog; MAX_STALL_CYCLES+1 cycles does.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Stall_Cycle_Count_o increments each non-reset cycle with Mem_Stall_i=1 and wraps modulo 2^32.
  - Load_Use_Count_o increments each cycle with ID_EX_Bubble_o=1 and saturates at 0xFFFF.
- HAZARD_PERF_CNT_EN undefined:
  - Both ports remain present, tied to 0; no counter flops are built.
  - All other behaviour is identical.

## Test plan
- Reset release → all four pipeline-control outputs follow the Else row (PC_Write_o=1, IF_ID_Write_o=1, ID_EX_Bubble_o=0, Pipeline_Stall_o=0); Stall_Timeout_o=0; all counters 0.
- lu with MemRead_EX_i=1, Write_Register_EX_i=5, Read_Register_2_ID_i=5 for one cycle → ID_EX_Bubble_o=1, PC_Write_o=0 in that cycle; Load_Use_Count_o=1 next cycle (macro on). Same stimulus with Write_Register_EX_i=0 → no bubble.
- Mem_Stall_i=1 for 3 cycles → Pipeline_Stall_o=1 for exactly those 3 cycles; Mem_Miss_Count_o=1; Stall_Cycle_Count_o=3.
- Mem_Stall_i=1 together with lu → ID_EX_Bubble_o=0 while stalled; the bubble appears in the first cycle after Mem_Stall_i drops.
- MAX_STALL_CYCLES=4:
  - Stall of 4 cycles → Stall_Timeout_o stays 0.
  - Stall of 5 cycles → Stall_Timeout_o=1, and it stays 1 after Mem_Stall_i drops until rst_i.
- rst_i pulsed during an active stall → counters clear; Mem_Miss_Count_o=1 after reset if Mem_Stall_i is still high.
